// File: rtl/riscv_lsu_pkg.sv
// -----------------------------------------------------------------------------
// riscv_lsu_pkg
//
// Shared definitions for the M-stage load/store unit:
//   - funct3 load/store encodings and the ResultSrc "load" encoding
//   - LSU bus FSM state type
//   - access-size decode helpers used by the top and by load_extend
// -----------------------------------------------------------------------------
package riscv_lsu_pkg;

    // ResultSrc value selecting the memory read path in writeback.
    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

    // Load funct3 encodings.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 encodings.
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic {
        LSU_IDLE = 1'b0,
        LSU_BUSY = 1'b1
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } lsu_size_e;

    // Load access size. Reserved codes (011, 110, 111) fall to word.
    function automatic lsu_size_e load_size(input logic [2:0] f3);
        case (f3)
            F3_LB, F3_LBU: return SIZE_BYTE;
            F3_LH, F3_LHU: return SIZE_HALF;
            F3_LW:         return SIZE_WORD;
            default:       return SIZE_WORD;
        endcase
    endfunction

    // Store access size. Only the low two bits carry size for stores, so the
    // unused sign bit is ignored; 011 and up fall to word.
    function automatic lsu_size_e store_size(input logic [2:0] f3);
        case ({1'b0, f3[1:0]})
            F3_SB:   return SIZE_BYTE;
            F3_SH:   return SIZE_HALF;
            F3_SW:   return SIZE_WORD;
            default: return SIZE_WORD;
        endcase
    endfunction

    // Zero-extending loads.
    function automatic logic load_unsigned(input logic [2:0] f3);
        return (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
//
// Purely combinational load-data aligner: picks the byte/halfword lane of the
// bus read word addressed by the low address bits and sign- or zero-extends
// it according to funct3. Word loads pass the bus word through unchanged.
//
// Ports:
//   rdata_i   [31:0] bus read word
//   offset_i  [1:0]  low bits of the effective byte address
//   funct3_i  [2:0]  load size/sign encoding
//   data_o    [31:0] extended load result
// -----------------------------------------------------------------------------
module load_extend
    import riscv_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_ext;

    assign sign_ext = ~load_unsigned(funct3_i);

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
    end

    // Halfword lane is chosen by bit 1 only; bit 0 is ignored here so that
    // an untrapped misaligned halfword reads the enclosing aligned half.
    assign half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        case (load_size(funct3_i))
            SIZE_BYTE: data_o = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SIZE_HALF: data_o = {{16{sign_ext & half_sel[15]}}, half_sel};
            default:   data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
//
// M-stage load/store unit for a 5-stage RISC-V pipeline. Issues a single
// word-addressed bus access per load/store, supports zero-wait completion in
// the issue cycle, stalls the pipeline while the bus is waiting, aborts the
// access with a one-cycle BusErrM pulse after TIMEOUT_CYCLES wait cycles, and
// produces the aligned, extended load result.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned halfword/word accesses are not issued; BusErrM
//               pulses instead and the pipeline is not stalled.
//   undefined : offending low address bits are ignored, no alignment error.
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles an access may wait for mem_ready (default 255)
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   MemWriteM       M-stage instruction is a store
//   ResultSrcM[1:0] 2'b01 marks a load
//   ALUResultM      effective byte address
//   WriteDataM      right-aligned store data
//   funct3M         access size/sign
//   mem_req/mem_we  bus request / write
//   mem_addr        word-aligned bus address
//   mem_wdata       lane-replicated store data
//   mem_be          byte enables (zero unless writing)
//   mem_ready       bus completes the access this cycle
//   mem_rdata       bus read word, valid with mem_ready
//   ReadDataM       extended load result, non-zero only on load completion
//   StallM          freeze F/D/E/M pipeline registers
//   BusErrM         one-cycle pulse on timeout or misalignment
// -----------------------------------------------------------------------------
module lsu_mem_stage
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemWriteM,
    input  logic [1:0]  ResultSrcM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        BusErrM
);

    localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        is_load;
    logic        access;
    lsu_size_e   acc_size;
    logic        fault;
    logic        timeout;
    logic [3:0]  be_full;
    logic [31:0] load_data;

    // -------------------------------------------------------------------------
    // Access decode
    // -------------------------------------------------------------------------
    assign is_load  = (ResultSrcM == RESULT_SRC_LOAD);
    assign access   = MemWriteM | is_load;
    assign acc_size = MemWriteM ? store_size(funct3M) : load_size(funct3M);

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        case (acc_size)
            SIZE_HALF: fault = access & ALUResultM[0];
            SIZE_WORD: fault = access & (|ALUResultM[1:0]);
            default:   fault = 1'b0;
        endcase
    end
`else
    assign fault = 1'b0;
`endif

    // Timeout fires only when the last allowed wait cycle passes without
    // mem_ready; a ready in that same cycle is an ordinary completion.
    assign timeout = (state_q == LSU_BUSY) && (cnt_q == CNT_LAST) && !mem_ready;

    // -------------------------------------------------------------------------
    // Store lane steering
    // -------------------------------------------------------------------------
    always_comb begin
        case (acc_size)
            SIZE_BYTE: begin
                be_full   = 4'b0001 << ALUResultM[1:0];
                mem_wdata = {4{WriteDataM[7:0]}};
            end
            SIZE_HALF: begin
                be_full   = 4'b0011 << {ALUResultM[1], 1'b0};
                mem_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_full   = 4'b1111;
                mem_wdata = WriteDataM;
            end
        endcase
    end

    assign mem_addr = {ALUResultM[31:2], 2'b00};

    load_extend u_load_extend (
        .rdata_i  (mem_rdata),
        .offset_i (ALUResultM[1:0]),
        .funct3_i (funct3M),
        .data_o   (load_data)
    );

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LSU_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of a combinational block
    // so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LSU_IDLE: begin
                if (access && !mem_ready && !fault) begin
                    state_d = LSU_BUSY;
                    cnt_d   = '0;
                end
            end
            LSU_BUSY: begin
                if (mem_ready || timeout) begin
                    state_d = LSU_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    // Everything is gated by rst_n: in IDLE mem_req follows the live access
    // inputs, so the state reset alone would not silence the bus during reset.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'b0000;
        StallM    = 1'b0;
        BusErrM   = 1'b0;
        ReadDataM = 32'h0;
        if (rst_n) begin
            case (state_q)
                LSU_IDLE: begin
                    mem_req = access & ~fault;
                    BusErrM = access & fault;
                end
                LSU_BUSY: begin
                    mem_req = 1'b1;
                    BusErrM = timeout;
                end
                default: ;
            endcase
            mem_we = mem_req & MemWriteM;
            mem_be = mem_we ? be_full : 4'b0000;
            StallM = access & ~(mem_req & mem_ready) & ~BusErrM;
            if (mem_req && mem_ready && is_load && !MemWriteM) begin
                ReadDataM = load_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_stage
//
// Directed plus randomized stimulus for lsu_mem_stage (TIMEOUT_CYCLES = 4).
// Expected values come from a transaction-level model: each access is
// described by its kind, funct3, address, data and the cycle at which the
// bus answers; the bench derives per-cycle outputs from those facts.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_lsu_mem_stage;

    localparam int TO = 4;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [2:0]  funct3M;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        BusErrM;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .MemWriteM  (MemWriteM),
        .ResultSrcM (ResultSrcM),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .funct3M    (funct3M),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .BusErrM    (BusErrM)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit misaligned(input logic [2:0] f3, input logic [31:0] a);
        int lo;
        lo = int'(a[1:0]);
        return (lo % nbytes(f3)) != 0;
    endfunction

    // Lowest byte index of the naturally aligned container of the access.
    function automatic int lane_base(input logic [2:0] f3, input logic [31:0] a);
        int lo;
        lo = int'(a[1:0]);
        return lo - (lo % nbytes(f3));
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes(f3);
        return 4'(((1 << n) - 1) << lane_base(f3, a));
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        case (nbytes(f3))
            1:       return (wd & 32'h0000_00FF) * 32'h0101_0101;
            2:       return (wd & 32'h0000_FFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
        int          n;
        logic [31:0] val, mask;
        n   = nbytes(f3);
        val = rd >> (8 * lane_base(f3, a));
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 32'h1;
            val  = val & mask;
            if (!f3[2] && val[8 * n - 1]) val = val | ~mask;
        end
        return val;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b00;
        mem_ready  = 1'b0;
    endtask

    // One cycle with no access; mem_ready may be driven to show it is ignored.
    task automatic idle_cycle(input string tag, input logic ready, input logic [1:0] rsrc);
        MemWriteM  = 1'b0;
        ResultSrcM = rsrc;
        mem_ready  = ready;
        mem_rdata  = $urandom;
        @(negedge clk);
        check({tag, ".req"},   mem_req,   0);
        check({tag, ".stall"}, StallM,    0);
        check({tag, ".err"},   BusErrM,   0);
        check({tag, ".rdata"}, ReadDataM, 0);
        @(posedge clk); #1;
        idle_inputs();
    endtask

    // Runs one access; the bus answers in cycle k (0 = issue cycle).
    // Entered and left just after a rising edge.
    task automatic run_access(input string tag, input bit is_store, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int k);
        bit flt, done, tout, req;
        int last;
        flt  = TRAP_EN && misaligned(f3, a);
        last = flt ? 0 : ((k <= TO) ? k : TO);
        MemWriteM  = is_store;
        ResultSrcM = is_store ? 2'b00 : 2'b01;
        ALUResultM = a;
        WriteDataM = wd;
        funct3M    = f3;
        for (int c = 0; c <= last; c++) begin
            mem_ready = (c == k);
            mem_rdata = (c == k) ? rd : $urandom;
            @(negedge clk);
            done = !flt && (c == k);
            tout = !flt && (c == TO) && (k > TO);
            req  = !flt;
            check({tag, ".req"}, mem_req, req);
            check({tag, ".we"},  mem_we,  req && is_store);
            if (req) check({tag, ".addr"}, mem_addr, {a[31:2], 2'b00});
            check({tag, ".be"}, mem_be, (req && is_store) ? exp_be(f3, a) : 4'b0000);
            if (req && is_store) check({tag, ".wdata"}, mem_wdata, exp_wdata(f3, wd));
            check({tag, ".stall"}, StallM,  !(done || tout || flt));
            check({tag, ".err"},   BusErrM, flt || tout);
            check({tag, ".rdata"}, ReadDataM, (done && !is_store) ? exp_load(f3, a, rd) : 32'h0);
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    // ---------------- sequence ----------------
    initial begin
        logic [2:0] store_f3 [6];
        store_f3 = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b110, 3'b111};

        // Reset with a store held on the inputs: all outputs stay low.
        rst_n      = 1'b0;
        MemWriteM  = 1'b1;
        ResultSrcM = 2'b00;
        ALUResultM = 32'h0000_0100;
        WriteDataM = 32'hFFFF_FFFF;
        funct3M    = 3'b010;
        mem_ready  = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        #2;
        check("rst.req",   mem_req,   0);
        check("rst.we",    mem_we,    0);
        check("rst.be",    mem_be,    0);
        check("rst.stall", StallM,    0);
        check("rst.err",   BusErrM,   0);
        check("rst.rdata", ReadDataM, 0);
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Zero-wait word store.
        run_access("sw0", 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);
        // Byte loads answered after 3 wait cycles.
        run_access("lb",  1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 3);
        run_access("lbu", 1'b0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_FFFF, 3);
        // Upper-half store.
        run_access("sh",  1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 1);
        // Halfword loads, signed and unsigned.
        run_access("lh",  1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h9876_0011, 0);
        run_access("lhu", 1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h9876_0011, 2);
        // Timeout: bus never answers, then a zero-wait access proves IDLE.
        run_access("tmo", 1'b0, 3'b010, 32'h0000_0200, 32'h0, 32'h1111_2222, 1000);
        run_access("post_tmo", 1'b0, 3'b010, 32'h0000_0204, 32'h0, 32'hCAFE_F00D, 0);
        // Ready arriving on the timeout cycle completes normally.
        run_access("edge_tmo", 1'b0, 3'b010, 32'h0000_0208, 32'h0, 32'h5555_AAAA, TO);
        // Misaligned word load and halfword store.
        run_access("lw_mis", 1'b0, 3'b010, 32'h0000_0101, 32'h0, 32'h0102_0304, 1);
        run_access("sh_mis", 1'b1, 3'b001, 32'h0000_0103, 32'h0000_BEEF, 32'h0, 0);
        // mem_ready with no request, and a non-load ResultSrc, are ignored.
        idle_cycle("rdy_noreq0", 1'b1, 2'b10);
        idle_cycle("rdy_noreq1", 1'b1, 2'b00);
        run_access("after_rdy", 1'b0, 3'b000, 32'h0000_0301, 32'h0, 32'h0000_7F00, 2);

        // Reset while waiting on the bus.
        MemWriteM  = 1'b0;
        ResultSrcM = 2'b01;
        funct3M    = 3'b010;
        ALUResultM = 32'h0000_0300;
        mem_ready  = 1'b0;
        @(negedge clk);
        check("rb.issue_stall", StallM, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rb.busy_req",   mem_req, 1);
        check("rb.busy_stall", StallM,  1);
        #1 rst_n = 1'b0;
        #1;
        check("rb.async_req",   mem_req,   0);
        check("rb.async_stall", StallM,    0);
        check("rb.async_err",   BusErrM,   0);
        check("rb.async_rdata", ReadDataM, 0);
        idle_inputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < TO + 2; i++) idle_cycle("rb.quiet", 1'b0, 2'b00);
        run_access("rb.clean0", 1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0BAD_F00D, 0);
        run_access("rb.clean1", 1'b1, 3'b000, 32'h0000_0302, 32'h0000_00A5, 32'h0, 2);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            bit         st;
            logic [2:0] f3;
            st = 1'($urandom_range(0, 1));
            f3 = st ? store_f3[$urandom_range(0, 5)] : 3'($urandom_range(0, 7));
            run_access($sformatf("rnd%0d", i), st, f3, $urandom, $urandom, $urandom,
                       int'($urandom_range(0, TO + 2)));
            if ($urandom_range(0, 3) == 0) idle_cycle("rnd_idle", 1'($urandom_range(0, 1)), 2'b11);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_mem_stage.md
LSU_MEM_STAGE -- requirements
Module: lsu_mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles a bus access may wait for mem_ready before it is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its posedge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port MemWriteM, input, 1 bit: the M-stage instruction is a store.
REQ-005 SHALL have port ResultSrcM, input, 2 bits: value 2'b01 means the M-stage instruction is a load.
REQ-006 SHALL have port ALUResultM, input, 32 bits: effective byte address.
REQ-007 SHALL have port WriteDataM, input, 32 bits: store data, right-aligned.
REQ-008 SHALL have port funct3M, input, 3 bits: access size and sign.
REQ-009 SHALL have port mem_req, output, 1 bit: bus request.
REQ-010 SHALL have port mem_we, output, 1 bit: bus write.
REQ-011 SHALL have port mem_addr, output, 32 bits: word address, {ALUResultM[31:2],2'b00}.
REQ-012 SHALL have port mem_wdata, output, 32 bits: lane-replicated store data.
REQ-013 SHALL have port mem_be, output, 4 bits: byte enables.
REQ-014 SHALL have port mem_ready, input, 1 bit: bus completes the access this cycle.
REQ-015 SHALL have port mem_rdata, input, 32 bits: bus read word, valid with mem_ready.
REQ-016 SHALL have port ReadDataM, output, 32 bits: extended load result for the MW register.
REQ-017 SHALL have port StallM, output, 1 bit: freeze F/D/E/M pipeline registers.
REQ-018 SHALL have port BusErrM, output, 1 bit: one-cycle pulse on timeout or misalignment.

Function
REQ-019 SHALL define access = MemWriteM | (ResultSrcM==2'b01).
REQ-020 SHALL implement FSM IDLE/BUSY: IDLE->BUSY when access & ~mem_ready & ~fault; BUSY->IDLE on mem_ready or timeout; otherwise hold.
REQ-021 SHALL drive mem_req = (IDLE & access & ~fault) | BUSY; mem_we = mem_req & MemWriteM.
REQ-022 SHALL allow zero-wait completion: mem_req & mem_ready in IDLE completes in the issue cycle, no stall.
REQ-023 SHALL drive StallM = access & ~(mem_req & mem_ready) & ~BusErrM.
REQ-024 SHALL set byte enables: SB 4'b0001<<a[1:0]; SH 4'b0011<<{a[1],1'b0}; SW 4'b1111; mem_be = 0 when not writing.
REQ-025 SHALL replicate store data: SB {4{wd[7:0]}}; SH {2{wd[15:0]}}; SW wd.
REQ-026 SHALL extract loads: LB/LBU select byte a[1:0]; LH/LHU select half a[1]; LW the full word; sign- or zero-extend per funct3 (000,001,010,100,101).
REQ-027 SHALL drive ReadDataM = 0 except in the completion cycle of a load.
REQ-028 SHALL keep a wait counter: cleared on entering BUSY, incremented each BUSY cycle; at count==TIMEOUT_CYCLES-1 without mem_ready, pulse BusErrM, deassert StallM, ReadDataM=0, return to IDLE.
REQ-029 SHALL, when mem_ready coincides with the timeout cycle, treat the access as completed normally, with no BusErrM.
REQ-030 SHALL ignore mem_ready while mem_req is 0.
REQ-031 SHALL treat funct3 values 011, 110 and 111 as word accesses.

Reset
REQ-032 SHALL, while rst_n is low, force state IDLE, counter 0, and mem_req, mem_we, mem_be, StallM, BusErrM and ReadDataM to 0.
REQ-033 SHALL, on rst_n assertion during BUSY, abandon the access immediately, with no completion or error pulse after release.

Configuration
REQ-034 SHALL support macro LSU_MISALIGN_TRAP_EN.
REQ-035 SHALL, with LSU_MISALIGN_TRAP_EN defined, flag fault for a halfword access with a[0]=1 or a word access with a[1:0]!=0; a faulting access issues no mem_req, pulses BusErrM for one cycle and does not stall.
REQ-036 SHALL, without LSU_MISALIGN_TRAP_EN, tie fault to 0, ignore the offending low address bits (halfword uses a[1], word uses none), and never raise BusErrM for alignment.

Structure
REQ-037 SHALL take funct3 load/store codes, the ResultSrc load encoding and the FSM state type from shared package riscv_lsu_pkg.
REQ-038 SHALL place load selection and extension in combinational sub-module load_extend.

Verification
REQ-039 Bench SHALL cover: SW a=0x100, wd=0xDEADBEEF, mem_ready same cycle -> mem_be=1111, mem_wdata=0xDEADBEEF, StallM=0.
REQ-040 Bench SHALL cover: LB a=0x103, mem_rdata=0x80FFFFFF, ready after 3 cycles -> StallM high 3 cycles, ReadDataM=0xFFFFFF80; LBU gives 0x00000080.
REQ-041 Bench SHALL cover: SH a=0x102, wd=0x1234ABCD -> mem_be=1100, mem_wdata=0xABCDABCD.
REQ-042 Bench SHALL cover: load with mem_ready held low, TIMEOUT_CYCLES=4 -> StallM for 4 cycles, BusErrM one pulse, ReadDataM=0, FSM back in IDLE.
REQ-043 Bench SHALL cover: LW a=0x101 -> with macro, no mem_req and BusErrM pulse; without macro, mem_addr=0x100 and normal load.
REQ-044 Bench SHALL cover: rst_n low during BUSY -> mem_req and StallM drop asynchronously; after release, the next access starts cleanly from IDLE.
